pipelined_rca: RTL and testbench
================================

Name: pipelined_rca

Overview:
- Parametrised, pipelined successor to the combinational ripple-carry adder.
- Splits the DATA_WIDTH carry chain into STAGES registered slices so clock frequency scales with width.
- Supports add and subtract per transaction and carries a valid/ready handshake with backpressure.
- Sits between operand producers and result consumers in datapath blocks that need wide adders at speed.

Parameters:
DATA_WIDTH, 8, operand width in bits; must be a multiple of STAGES
STAGES, 2, pipeline depth and number of carry-chain slices; 1..DATA_WIDTH
SLICE_W, DATA_WIDTH/STAGES, derived localparam, bits added per stage

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands present
in_ready  output  1  block accepts operands this cycle
a  input  DATA_WIDTH  operand A (unsigned or two's complement)
b  input  DATA_WIDTH  operand B
sub  input  1  0: a+b, 1: a-b
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
result  output  DATA_WIDTH  sum/difference, low DATA_WIDTH bits
cout  output  1  final carry; for sub, 1 = no borrow (a >= b unsigned)
ovf  output  1  signed overflow

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits 0, all data/carry registers 0. out_valid=0, result=0, cout=0, ovf=0. in_ready=1 once rst_n deasserts. Reset mid-flight discards every in-flight transaction; no partial output.
- Subtraction: b_eff = ~b, carry-in = 1. Addition: b_eff = b, carry-in = 0. Inversion happens at acceptance.
- Stage k (0..STAGES-1) adds bits [k*SLICE_W +: SLICE_W] of a and b_eff plus the carry registered by stage k-1 (stage 0 uses the carry-in).
- Each stage registers:
  - its slice result and carry-out;
  - the already-computed lower result bits;
  - the not-yet-used upper operand bits, skewed forward;
  - the MSB carry-in needed for ovf.
- Latency: exactly STAGES cycles from acceptance (in_valid && in_ready) to out_valid, if no stall. Throughput: 1 per cycle.
- Global stall: advance = !out_valid || out_ready. in_ready = advance (combinational, no dependency on in_valid). When advance=0, every stage register holds. When advance=1, every stage shifts and stage 0 loads the new operand (valid = in_valid && in_ready).
- Bubbles are not collapsed; an empty stage still shifts only when advance=1.
- out_valid/result/cout/ovf are the last-stage registers; they are stable while out_valid && !out_ready.
- cout = carry out of bit DATA_WIDTH-1. ovf = carry into MSB XOR carry out of MSB.
- Simultaneous out handshake and new acceptance in the same cycle: legal, no bubble inserted.
- STAGES=1 degenerates to a single registered adder with latency 1.
- in_valid while in_ready=0: operands ignored; the producer must hold them (standard valid/ready).

Decomposition:
- Package pipelined_rca_pkg holds:
  - the OP_ADD/OP_SUB encoding;
  - a stage-register struct type (valid, partial result, carry, remaining a/b_eff bits, msb_cin);
  - a helper function checking DATA_WIDTH % STAGES == 0 for an elaboration-time assertion.
- One sub-module: rca_slice, a combinational SLICE_W-bit ripple adder with cin, cout, and the carry into its MSB. It is built from the existing full_adder cell and instantiated STAGES times in a generate loop.

Test Plan:
- DATA_WIDTH=8, STAGES=2, out_ready=1: a=0x5A, b=0x3C, sub=0 accepted at cycle 0 -> out_valid at cycle 2, result=0x96, cout=0, ovf=1.
- Subtract: a=0x10, b=0x20, sub=1 -> result=0xF0, cout=0 (borrow), ovf=0; then a=0x80, b=0x01, sub=1 -> result=0x7F, cout=1, ovf=1.
- Back-to-back stream of 16 random ops with in_valid held high -> 16 consecutive out_valid cycles starting at cycle 2, each result matching the reference model, in order.
- Backpressure: out_ready=0 for 5 cycles with the pipe full -> in_ready=0, result/cout/ovf frozen. Release out_ready -> no lost or duplicated results.
- Reset mid-operation: assert rst_n=0 with 2 transactions in flight -> out_valid=0 and result=0 immediately (asynchronous). After release, the next op emerges with latency 2 and no stale output.
- Width sweep: DATA_WIDTH=32, STAGES=4 and STAGES=1, a=0xFFFFFFFF, b=0x00000001, sub=0 -> result=0, cout=1, ovf=0, latency 4 and 1 respectively.

Source files
------------

// File: rtl/pipelined_rca_pkg.sv
// Shared types and helpers for the pipelined ripple-carry adder.
//   op_e          : per-transaction operation encoding (add / subtract)
//   stage_ctrl_t  : width-independent part of a pipeline stage register
//   rca_cfg_ok()  : elaboration-time legality check of DATA_WIDTH / STAGES
package pipelined_rca_pkg;

    typedef enum logic {
        OP_ADD = 1'b0,
        OP_SUB = 1'b1
    } op_e;

    // Per-stage control bits. The width-dependent fields (partial result and
    // remaining a / b_eff bits) sit beside this struct in the top module,
    // because their widths follow the top-level parameters.
    typedef struct packed {
        logic valid;
        logic carry;
        logic msb_cin;
    } stage_ctrl_t;

    function automatic bit rca_cfg_ok(input int unsigned width, input int unsigned stages);
        return (stages >= 1) && (stages <= width) && ((width % stages) == 0);
    endfunction

endpackage

// File: rtl/full_adder.sv
// One-bit full adder cell.
//   a, b, cin : addend bits and carry-in
//   sum, cout : sum bit and carry-out
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/pipelined_rca_slice.sv
// Combinational W-bit ripple-carry slice built from full_adder cells.
//   a, b    : slice operands
//   cin     : carry into bit 0
//   sum     : slice sum
//   cout    : carry out of bit W-1
//   msb_cin : carry into bit W-1 (feeds signed-overflow detection)
module rca_slice #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] sum,
    output logic         cout,
    output logic         msb_cin
);

    logic [W:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < W; i++) begin : g_bit
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .sum  (sum[i]),
            .cout (c[i+1])
        );
    end

    assign cout    = c[W];
    assign msb_cin = c[W-1];

endmodule

// File: rtl/pipelined_rca.sv
// Pipelined ripple-carry adder/subtractor with valid/ready handshake.
// The carry chain is cut into STAGES slices of SLICE_W bits; each stage
// registers its slice, so one operand pair moves through per cycle.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : operand handshake (in_ready = pipeline may advance)
//   a, b, sub           : operands, sub=1 selects a-b
//   out_valid/out_ready : result handshake
//   result, cout, ovf   : low DATA_WIDTH bits, final carry, signed overflow
module pipelined_rca
    import pipelined_rca_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned STAGES     = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] a,
    input  logic [DATA_WIDTH-1:0] b,
    input  logic                  sub,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] result,
    output logic                  cout,
    output logic                  ovf
);

    localparam int unsigned SLICE_W = DATA_WIDTH / STAGES;

    if (!rca_cfg_ok(DATA_WIDTH, STAGES)) begin : g_cfg_check
        $error("pipelined_rca: DATA_WIDTH must be a nonzero multiple of STAGES");
    end

    // Registered view of every stage, indexed by stage number.
    stage_ctrl_t           ctrl_arr  [STAGES];
    logic [DATA_WIDTH-1:0] res_arr   [STAGES];
    logic [DATA_WIDTH-1:0] a_rem_arr [STAGES];
    logic [DATA_WIDTH-1:0] b_rem_arr [STAGES];

    logic                  advance;
    logic [DATA_WIDTH-1:0] b_eff;

    // Global stall: the whole pipe moves only when the tail can drain.
    always_comb begin
        advance = !ctrl_arr[STAGES-1].valid || out_ready;
        b_eff   = (op_e'(sub) == OP_SUB) ? ~b : b;
    end

    assign in_ready = advance;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        stage_ctrl_t           ctrl_d,  ctrl_q;
        logic [DATA_WIDTH-1:0] res_d,   res_q;
        logic [DATA_WIDTH-1:0] a_rem_d, a_rem_q;
        logic [DATA_WIDTH-1:0] b_rem_d, b_rem_q;

        logic                  in_v;
        logic                  in_cin;
        logic [DATA_WIDTH-1:0] in_a;
        logic [DATA_WIDTH-1:0] in_b;
        logic [DATA_WIDTH-1:0] in_res;

        logic [SLICE_W-1:0]    sl_sum;
        logic                  sl_cout;
        logic                  sl_msb_cin;

        // Stage input: fresh operands at the head, previous stage otherwise.
        if (k == 0) begin : g_head
            always_comb begin
                in_v   = in_valid;
                in_cin = sub;
                in_a   = a;
                in_b   = b_eff;
                in_res = '0;
            end
        end else begin : g_body
            always_comb begin
                in_v   = ctrl_arr[k-1].valid;
                in_cin = ctrl_arr[k-1].carry;
                in_a   = a_rem_arr[k-1];
                in_b   = b_rem_arr[k-1];
                in_res = res_arr[k-1];
            end
        end

        // Remaining operand bits are kept right-aligned, so every stage
        // consumes the low SLICE_W bits.
        rca_slice #(
            .W (SLICE_W)
        ) u_slice (
            .a       (in_a[SLICE_W-1:0]),
            .b       (in_b[SLICE_W-1:0]),
            .cin     (in_cin),
            .sum     (sl_sum),
            .cout    (sl_cout),
            .msb_cin (sl_msb_cin)
        );

        // Next-state: hold on stall, otherwise capture this stage's slice.
        always_comb begin
            ctrl_d  = ctrl_q;
            res_d   = res_q;
            a_rem_d = a_rem_q;
            b_rem_d = b_rem_q;
            if (advance) begin
                ctrl_d.valid   = in_v;
                ctrl_d.carry   = sl_cout;
                ctrl_d.msb_cin = sl_msb_cin;
                res_d          = in_res;
                res_d[k*SLICE_W +: SLICE_W] = sl_sum;
                a_rem_d        = in_a >> SLICE_W;
                b_rem_d        = in_b >> SLICE_W;
            end
        end

        // Stage register.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                ctrl_q  <= '0;
                res_q   <= '0;
                a_rem_q <= '0;
                b_rem_q <= '0;
            end else begin
                ctrl_q  <= ctrl_d;
                res_q   <= res_d;
                a_rem_q <= a_rem_d;
                b_rem_q <= b_rem_d;
            end
        end

        assign ctrl_arr[k]  = ctrl_q;
        assign res_arr[k]   = res_q;
        assign a_rem_arr[k] = a_rem_q;
        assign b_rem_arr[k] = b_rem_q;
    end

    // Outputs come straight from the last stage register.
    assign out_valid = ctrl_arr[STAGES-1].valid;
    assign result    = res_arr[STAGES-1];
    assign cout      = ctrl_arr[STAGES-1].carry;
    assign ovf       = ctrl_arr[STAGES-1].carry ^ ctrl_arr[STAGES-1].msb_cin;

endmodule

// File: tb/tb_pipelined_rca.sv
// Scoreboard bench for pipelined_rca: stimulus pushes expected results,
// an independent monitor pops and compares on every output handshake.
`timescale 1ns/1ps
module tb_pipelined_rca;

    localparam int unsigned W  = 8;
    localparam int unsigned S  = 2;
    localparam int unsigned WW = 32;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic         in_valid, in_ready, sub, out_valid, out_ready, cout, ovf;
    logic [W-1:0] a, b, result;

    logic          w_in_valid, w_sub, w_out_ready;
    logic [WW-1:0] w_a, w_b;
    logic          w4_in_ready, w4_out_valid, w4_cout, w4_ovf;
    logic [WW-1:0] w4_result;
    logic          w1_in_ready, w1_out_valid, w1_cout, w1_ovf;
    logic [WW-1:0] w1_result;

    pipelined_rca #(.DATA_WIDTH(W), .STAGES(S)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .cout(cout), .ovf(ovf)
    );

    pipelined_rca #(.DATA_WIDTH(WW), .STAGES(4)) dut_w4 (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w4_in_ready),
        .a(w_a), .b(w_b), .sub(w_sub), .out_valid(w4_out_valid), .out_ready(w_out_ready),
        .result(w4_result), .cout(w4_cout), .ovf(w4_ovf)
    );

    pipelined_rca #(.DATA_WIDTH(WW), .STAGES(1)) dut_w1 (
        .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w1_in_ready),
        .a(w_a), .b(w_b), .sub(w_sub), .out_valid(w1_out_valid), .out_ready(w_out_ready),
        .result(w1_result), .cout(w1_cout), .ovf(w1_ovf)
    );

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         v;
        int           acc;
        bit           lat;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   chk_cnt = 0;
    int   pass_cnt = 0;
    int   cyc = 0;
    int   n_push = 0;
    int   n_pop = 0;
    bit   rnd_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Reference: plain integer arithmetic on the operand values.
    function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                   input logic ms, input int acc, input bit lat);
        exp_t e;
        int ua, ub, sa, sbv, r, sr;
        ua  = int'(ma);
        ub  = int'(mb);
        sa  = int'($signed(ma));
        sbv = int'($signed(mb));
        if (ms) begin
            r   = ua - ub;
            e.c = (ua >= ub);
            sr  = sa - sbv;
        end else begin
            r   = ua + ub;
            e.c = (r >= (1 << W));
            sr  = sa + sbv;
        end
        e.res = W'(r);
        e.v   = (sr > ((1 << (W-1)) - 1)) || (sr < -(1 << (W-1)));
        e.acc = acc;
        e.lat = lat;
        return e;
    endfunction

    // Monitor: compare every result that is handed over.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            n_pop++;
            if (sb.size() == 0) begin
                chk_cnt++;
                $display("FAIL unexpected_output: got result 0x%0h, expected no output", result);
            end else begin
                mon_e = sb.pop_front();
                check("result", 64'(result), 64'(mon_e.res));
                check("cout", 64'(cout), 64'(mon_e.c));
                check("ovf", 64'(ovf), 64'(mon_e.v));
                if (mon_e.lat) check("latency", 64'(cyc - mon_e.acc), 64'(S));
            end
        end
    end

    // Present operands and hold them until accepted.
    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts, input bit lat);
        a = ta; b = tb_v; sub = ts; in_valid = 1'b1;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(model(ta, tb_v, ts, cyc, lat));
                n_push++;
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        chk_cnt++;
        $display("FAIL send_timeout: in_ready got 0 for 200 cycles, expected 1");
    endtask

    // Single op with fixed expected values and exact two-cycle latency.
    task automatic directed(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic ts,
                            input logic [W-1:0] er, input logic ec, input logic ev);
        send(ta, tb_v, ts, 1'b1);
        in_valid = 1'b0;
        @(negedge clk);
        check("dir_early_valid", 64'(out_valid), 64'(0));
        @(posedge clk);
        @(negedge clk);
        check("dir_valid", 64'(out_valid), 64'(1));
        check("dir_result", 64'(result), 64'(er));
        check("dir_cout", 64'(cout), 64'(ec));
        check("dir_ovf", 64'(ovf), 64'(ev));
        @(posedge clk); #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 100; i++) begin
            if (sb.size() == 0) break;
            @(posedge clk);
        end
        @(posedge clk); #1;
        check("drain_empty", 64'(sb.size()), 64'(0));
        check("push_pop_count", 64'(n_pop), 64'(n_push));
    endtask

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        exp_t ea;
        int   lat4, lat1;
        in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; out_ready = 1'b1;
        w_in_valid = 1'b0; w_a = '0; w_b = '0; w_sub = 1'b0; w_out_ready = 1'b1;

        // Reset state.
        #1 rst_n = 1'b0;
        #1;
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_result", 64'(result), 64'(0));
        check("rst_cout", 64'(cout), 64'(0));
        check("rst_ovf", 64'(ovf), 64'(0));
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        #1 check("rst_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;

        // Directed add / subtract cases.
        directed(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
        directed(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
        directed(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        drain();

        // Width sweep: 32 bits with 4 stages and with 1 stage.
        w_a = 32'hFFFF_FFFF; w_b = 32'h0000_0001; w_sub = 1'b0; w_in_valid = 1'b1;
        @(negedge clk);
        check("w4_in_ready", 64'(w4_in_ready), 64'(1));
        check("w1_in_ready", 64'(w1_in_ready), 64'(1));
        @(posedge clk); #1;
        w_in_valid = 1'b0;
        lat4 = -1; lat1 = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (w4_out_valid && lat4 < 0) begin
                lat4 = k;
                check("w4_result", 64'(w4_result), 64'(0));
                check("w4_cout", 64'(w4_cout), 64'(1));
                check("w4_ovf", 64'(w4_ovf), 64'(0));
            end
            if (w1_out_valid && lat1 < 0) begin
                lat1 = k;
                check("w1_result", 64'(w1_result), 64'(0));
                check("w1_cout", 64'(w1_cout), 64'(1));
                check("w1_ovf", 64'(w1_ovf), 64'(0));
            end
        end
        check("w4_latency", 64'(lat4), 64'(4));
        check("w1_latency", 64'(lat1), 64'(1));
        @(posedge clk); #1;

        // Back-to-back random stream, latency checked on every result.
        for (int i = 0; i < 16; i++)
            send(W'($urandom), W'($urandom), 1'($urandom), 1'b1);
        in_valid = 1'b0;
        drain();

        // Backpressure: fill the pipe, stall 5 cycles, release.
        out_ready = 1'b0;
        ea = model(8'hC3, 8'h7E, 1'b0, 0, 1'b0);
        send(8'hC3, 8'h7E, 1'b0, 1'b0);
        send(8'h21, 8'h43, 1'b1, 1'b0);
        a = 8'h99; b = 8'h66; sub = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready), 64'(0));
            check("stall_out_valid", 64'(out_valid), 64'(1));
            check("stall_result", 64'(result), 64'(ea.res));
            check("stall_cout", 64'(cout), 64'(ea.c));
            check("stall_ovf", 64'(ovf), 64'(ea.v));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(8'h99, 8'h66, 1'b1, 1'b0);
        in_valid = 1'b0;
        drain();

        // Random traffic with random consumer backpressure.
        fork
            begin
                for (int i = 0; i < 30; i++)
                    send(W'($urandom), W'($urandom), 1'($urandom), 1'b0);
                in_valid = 1'b0;
                rnd_done = 1'b1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        join
        out_ready = 1'b1;
        drain();

        // Reset with two transactions in flight.
        send(8'h11, 8'h22, 1'b0, 1'b0);
        send(8'h33, 8'h44, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_result", 64'(result), 64'(0));
        check("midrst_cout", 64'(cout), 64'(0));
        check("midrst_ovf", 64'(ovf), 64'(0));
        sb.delete();
        n_push = n_pop;
        in_valid = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("postrst_in_ready", 64'(in_ready), 64'(1));
        check("postrst_out_valid", 64'(out_valid), 64'(0));
        directed(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        drain();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("no_stale_output", 64'(out_valid), 64'(0));
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
